// File: rtl/press_classifier_pkg.sv
// Shared types and default timing constants for the press classifier
// and the blocks around it (UI logic, bench).
package press_classifier_pkg;

  localparam int unsigned LONG_CYCLES_DEF   = 16;
  localparam int unsigned REPEAT_CYCLES_DEF = 8;
  localparam int unsigned CNT_W_DEF         = 5;

  // Encoding 2'd3 is unused and recovers to ST_IDLE
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_t;

  typedef struct packed {
    logic short_press;
    logic long_press;
    logic repeat_tick;
    logic long_release;
    logic held;
  } press_out_t;

endpackage

// File: rtl/press_classifier.sv
// Classifies button presses from edge-detector pulses as short or long and
// emits auto-repeat ticks while a long press is held. All outputs registered.
module press_classifier
  import press_classifier_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rise_in,
  input  logic fall_in,
  output logic short_press,
  output logic long_press,
  output logic repeat_tick,
  output logic long_release,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  press_out_t        out_q, out_n;
  logic              rise, fall;

  // Simultaneous rise and fall is illegal upstream: treat as no event
  assign rise = rise_in & ~fall_in;
  assign fall = fall_in & ~rise_in;

  // State, shared counter and registered pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      out_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      out_q <= out_n;
    end
  end

  // Next state, counter and next-cycle outputs; release beats the threshold
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    out_n   = '0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_n = ST_PRESSED;
          cnt_n   = '0;
        end
      end
      ST_PRESSED: begin
        if (fall) begin
          state_n           = ST_IDLE;
          cnt_n             = '0;
          out_n.short_press = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_n          = ST_LONG;
          cnt_n            = '0;
          out_n.long_press = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_LONG: begin
        if (fall) begin
          state_n            = ST_IDLE;
          cnt_n              = '0;
          out_n.long_release = 1'b1;
        end else if (cnt == REPEAT_LAST) begin
          cnt_n             = '0;
          out_n.repeat_tick = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
    out_n.held = (state_n != ST_IDLE);
  end

  assign short_press  = out_q.short_press;
  assign long_press   = out_q.long_press;
  assign repeat_tick  = out_q.repeat_tick;
  assign long_release = out_q.long_release;
  assign held         = out_q.held;

endmodule

// File: tb/tb_press_classifier.sv
// Self-checking bench for press_classifier with LONG_CYCLES=8, REPEAT_CYCLES=4.
module tb_press_classifier;

  localparam int L = 8;
  localparam int R = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic rise_in;
  logic fall_in;
  logic short_press, long_press, repeat_tick, long_release, held;

  always #5 clk = ~clk;

  press_classifier #(
    .LONG_CYCLES  (L),
    .REPEAT_CYCLES(R),
    .CNT_W        (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rise_in     (rise_in),
    .fall_in     (fall_in),
    .short_press (short_press),
    .long_press  (long_press),
    .repeat_tick (repeat_tick),
    .long_release(long_release),
    .held        (held)
  );

  typedef struct {
    int hold;        // edge of the fall, rise is at edge 0
    bit pre_both;    // rise+fall together while idle, before the press
    bit stray_fall;  // fall while idle, before the press
    int extra_rise;  // edge of a second rise (0 = none)
    int both_edge;   // edge with rise+fall together (0 = none)
    int gap;         // idle edges after the fall
    int exp_short;
    int exp_long;
    int exp_ticks;
    int exp_rel;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl [NV];

  int total = 0;
  int bad   = 0;
  logic [4:0] sb_q [$];
  int n_short, n_long, n_tick, n_rel;

  function automatic logic [4:0] outs();
    return {short_press, long_press, repeat_tick, long_release, held};
  endfunction

  // Closed-form expectation for outputs after edge k: {short,long,tick,rel,held}
  function automatic logic [4:0] exp_at(int k, int h);
    logic s, l, t, r, hd;
    s = 1'b0; l = 1'b0; t = 1'b0; r = 1'b0; hd = 1'b0;
    if (k >= 0 && k < h) begin
      hd = 1'b1;
      if (h > L && k == L) l = 1'b1;
      if (h > L && k > L && ((k - L) % R) == 0) t = 1'b1;
    end else if (k == h) begin
      s = (h <= L);
      r = (h > L);
    end
    return {s, l, t, r, hd};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (short,long,tick,rel,held) at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge
  task automatic step(input logic r, input logic f, input logic [4:0] e, input string name);
    logic [4:0] act;
    logic [4:0] want;
    @(negedge clk);
    rise_in = r;
    fall_in = f;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    act  = outs();
    want = sb_q.pop_front();
    check(name, act, want);
    n_short += int'(act[4]);
    n_long  += int'(act[3]);
    n_tick  += int'(act[2]);
    n_rel   += int'(act[1]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want done");
    $fatal(1, "timeout");
  end

  initial begin
    logic r, f;
    tbl[0]  = '{5,  0, 0, 0,  0, 2, 1, 0, 0, 0};
    tbl[1]  = '{8,  0, 0, 0,  0, 2, 1, 0, 0, 0};
    tbl[2]  = '{20, 0, 0, 0,  0, 2, 0, 1, 2, 1};
    tbl[3]  = '{1,  0, 0, 0,  0, 0, 1, 0, 0, 0};
    tbl[4]  = '{9,  0, 0, 0,  0, 2, 0, 1, 0, 1};
    tbl[5]  = '{12, 0, 0, 0,  0, 2, 0, 1, 0, 1};
    tbl[6]  = '{13, 0, 0, 0,  0, 2, 0, 1, 1, 1};
    tbl[7]  = '{6,  1, 0, 0,  3, 2, 1, 0, 0, 0};
    tbl[8]  = '{6,  0, 1, 2,  0, 2, 1, 0, 0, 0};
    tbl[9]  = '{14, 0, 0, 10, 0, 2, 0, 1, 1, 1};
    tbl[10] = '{17, 0, 0, 0,  0, 2, 0, 1, 2, 1};

    rst_n   = 1'b0;
    rise_in = 1'b0;
    fall_in = 1'b0;
    #12;
    check("reset_state", outs(), 5'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < NV; v++) begin
      n_short = 0; n_long = 0; n_tick = 0; n_rel = 0;
      if (tbl[v].pre_both)   step(1'b1, 1'b1, 5'b0, $sformatf("v%0d_idle_both", v));
      if (tbl[v].stray_fall) step(1'b0, 1'b1, 5'b0, $sformatf("v%0d_idle_fall", v));
      for (int k = 0; k <= tbl[v].hold + tbl[v].gap; k++) begin
        r = (k == 0) || (tbl[v].extra_rise > 0 && k == tbl[v].extra_rise)
                     || (tbl[v].both_edge > 0 && k == tbl[v].both_edge);
        f = (k == tbl[v].hold) || (tbl[v].both_edge > 0 && k == tbl[v].both_edge);
        step(r, f, exp_at(k, tbl[v].hold), $sformatf("v%0d_h%0d_e%0d", v, tbl[v].hold, k));
      end
      total++;
      if (n_short != tbl[v].exp_short || n_long != tbl[v].exp_long ||
          n_tick != tbl[v].exp_ticks || n_rel != tbl[v].exp_rel) begin
        bad++;
        $display("FAIL v%0d_counts: got s%0d l%0d t%0d r%0d want s%0d l%0d t%0d r%0d", v,
                 n_short, n_long, n_tick, n_rel,
                 tbl[v].exp_short, tbl[v].exp_long, tbl[v].exp_ticks, tbl[v].exp_rel);
      end
    end

    // Async reset while long_press is high: everything drops at once
    step(1'b1, 1'b0, exp_at(0, 100), "rst_seq_e0");
    for (int k = 1; k <= L; k++) step(1'b0, 1'b0, exp_at(k, 100), $sformatf("rst_seq_e%0d", k));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_now", outs(), 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 5'b0, "post_reset_release");
    step(1'b0, 1'b0, 5'b0, "post_reset_idle");
    for (int k = 0; k <= 5; k++) begin
      step(k == 0, k == 3, exp_at(k, 3), $sformatf("post_reset_press_e%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
